map_step_ctrl: RTL

Game-step sequencer for the two-player light-cycle map. It owns the single write/read port of the 64x48 tile-map RAM. It clears and frames the map on game start, places both players, and advances both players by one tile on every game tick. On each step it reads the target tiles, decides collisions and the winner, writes the player trails, and drives the game mode consumed by the screen-select and rendering logic.

---
 rtl/map_step_ctrl.sv | 361 ++++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/map_step_ctrl.sv
// ---------------------------------------------------------------------------
// map_step_ctrl
//
// Game-step sequencer for the two-player light-cycle map. Owns the single
// read/write port of the 64x48 tile-map RAM: clears and frames the map on
// game start, places both players, and on every accepted tick reads the two
// target tiles, resolves collisions/winner and writes both trails.
//
// Ports:
//   clk        system clock (single domain)
//   rst        synchronous, active-high reset
//   start      one-cycle pulse, begins a new game from START or an end mode
//   tick       one-cycle game-step pulse (only honoured in GAME_WAIT)
//   dir1/dir2  requested direction: WAIT=0 RIGHT=1 LEFT=2 UP=3 DOWN=4
//   map_addr   RAM address {y[5:0], x[5:0]}
//   map_we     RAM write enable
//   map_wdata  tile code: EMPTY=0 PLAYER1=1 PLAYER2=2 FRAME=3
//   map_rdata  RAM read data, valid one cycle after a read address
//   mode       START=0 GAME=1 PLAYER1_WIN=2 PLAYER2_WIN=3 GAME_OVER=4
//   x1..y2     current head positions (upper two bits always zero)
//   busy       high outside IDLE_START, GAME_WAIT and END
//
// All outputs are registered: the next-state logic also computes the next
// value of every output, so an output always reflects the state it is in.
// ---------------------------------------------------------------------------
module map_step_ctrl #(
    parameter int MAP_WIDTH  = 64,
    parameter int MAP_HEIGHT = 48,
    parameter int START_X1   = 24,
    parameter int START_Y1   = 18,
    parameter int START_X2   = 40,
    parameter int START_Y2   = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        tick,
    input  logic [2:0]  dir1,
    input  logic [2:0]  dir2,
    output logic [11:0] map_addr,
    output logic        map_we,
    output logic [2:0]  map_wdata,
    input  logic [2:0]  map_rdata,
    output logic [2:0]  mode,
    output logic [7:0]  x1,
    output logic [7:0]  y1,
    output logic [7:0]  x2,
    output logic [7:0]  y2,
    output logic        busy
);

    // Direction codes
    localparam logic [2:0] DIR_WAIT  = 3'd0;
    localparam logic [2:0] DIR_RIGHT = 3'd1;
    localparam logic [2:0] DIR_LEFT  = 3'd2;
    localparam logic [2:0] DIR_UP    = 3'd3;
    localparam logic [2:0] DIR_DOWN  = 3'd4;

    // Tile codes
    localparam logic [2:0] TILE_EMPTY   = 3'd0;
    localparam logic [2:0] TILE_PLAYER1 = 3'd1;
    localparam logic [2:0] TILE_PLAYER2 = 3'd2;
    localparam logic [2:0] TILE_FRAME   = 3'd3;

    // Game modes
    localparam logic [2:0] MODE_START       = 3'd0;
    localparam logic [2:0] MODE_GAME        = 3'd1;
    localparam logic [2:0] MODE_PLAYER1_WIN = 3'd2;
    localparam logic [2:0] MODE_PLAYER2_WIN = 3'd3;
    localparam logic [2:0] MODE_GAME_OVER   = 3'd4;

    localparam logic [5:0] X_LAST = 6'(MAP_WIDTH - 1);
    localparam logic [5:0] Y_LAST = 6'(MAP_HEIGHT - 1);
    localparam logic [7:0] SX1    = 8'(START_X1);
    localparam logic [7:0] SY1    = 8'(START_Y1);
    localparam logic [7:0] SX2    = 8'(START_X2);
    localparam logic [7:0] SY2    = 8'(START_Y2);

    typedef enum logic [3:0] {
        S_IDLE_START,
        S_CLEAR,
        S_PLACE1,
        S_PLACE2,
        S_GAME_WAIT,
        S_RD1,
        S_RD2,
        S_CHK,
        S_WR1,
        S_WR2,
        S_END
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cx_q, cx_d;          // clear walk column
    logic [5:0]  cy_q, cy_d;          // clear walk row
    logic [2:0]  head1_q, head1_d;
    logic [2:0]  head2_q, head2_d;
    logic [7:0]  n1x_q, n1x_d, n1y_q, n1y_d;
    logic [7:0]  n2x_q, n2x_d, n2y_q, n2y_d;
    logic [2:0]  tile1_q, tile1_d;    // tile found at n1
    logic [7:0]  x1_d, y1_d, x2_d, y2_d;
    logic [2:0]  mode_d;
    logic [11:0] map_addr_d;
    logic        map_we_d;
    logic [2:0]  map_wdata_d;
    logic        busy_d;
    logic        same_tile;
    logic        hit1;
    logic        hit2;

    // A reversal request is dropped so a cycle can never drive straight back
    // into its own trail. Codes above DOWN carry no direction and are treated
    // like WAIT.
    function automatic logic [2:0] new_heading(input logic [2:0] cur,
                                               input logic [2:0] req);
        logic opposite;
        opposite = (cur == DIR_RIGHT && req == DIR_LEFT)  ||
                   (cur == DIR_LEFT  && req == DIR_RIGHT) ||
                   (cur == DIR_UP    && req == DIR_DOWN)  ||
                   (cur == DIR_DOWN  && req == DIR_UP);
        if (req == DIR_WAIT || req > DIR_DOWN || opposite)
            return cur;
        return req;
    endfunction

    // One tile forward; returns {y, x}. The frame always stops a player
    // before the arithmetic could leave the map, so no wrap handling.
    function automatic logic [15:0] next_pos(input logic [7:0] x,
                                             input logic [7:0] y,
                                             input logic [2:0] h);
        logic [7:0] nx;
        logic [7:0] ny;
        nx = x;
        ny = y;
        case (h)
            DIR_RIGHT: nx = x + 8'd1;
            DIR_LEFT:  nx = x - 8'd1;
            DIR_UP:    ny = y - 8'd1;
            DIR_DOWN:  ny = y + 8'd1;
            default:   ;
        endcase
        return {ny, nx};
    endfunction

    function automatic logic is_frame(input logic [5:0] x, input logic [5:0] y);
        return (x == 6'd0) || (x == X_LAST) || (y == 6'd0) || (y == Y_LAST);
    endfunction

    // Next-state and next-output logic
    always_comb begin
        // NOTE: every variable gets a default before the case so that no path
        // leaves it unassigned; a missing default would infer a latch.
        state_d     = state_q;
        cx_d        = cx_q;
        cy_d        = cy_q;
        head1_d     = head1_q;
        head2_d     = head2_q;
        n1x_d       = n1x_q;
        n1y_d       = n1y_q;
        n2x_d       = n2x_q;
        n2y_d       = n2y_q;
        tile1_d     = tile1_q;
        x1_d        = x1;
        y1_d        = y1;
        x2_d        = x2;
        y2_d        = y2;
        mode_d      = mode;
        map_addr_d  = 12'd0;
        map_we_d    = 1'b0;
        map_wdata_d = TILE_EMPTY;
        busy_d      = 1'b1;
        same_tile   = 1'b0;
        hit1        = 1'b0;
        hit2        = 1'b0;

        case (state_q)
            S_IDLE_START, S_END: begin
                // start beats a simultaneous tick here
                if (start) begin
                    state_d = S_CLEAR;
                    cx_d    = 6'd0;
                    cy_d    = 6'd0;
                end
            end

            S_CLEAR: begin
                if (cx_q == X_LAST && cy_q == Y_LAST) begin
                    state_d = S_PLACE1;
                    x1_d    = SX1;
                    y1_d    = SY1;
                    head1_d = DIR_RIGHT;
                end else if (cx_q == X_LAST) begin
                    cx_d = 6'd0;
                    cy_d = cy_q + 6'd1;
                end else begin
                    cx_d = cx_q + 6'd1;
                end
            end

            S_PLACE1: begin
                state_d = S_PLACE2;
                x2_d    = SX2;
                y2_d    = SY2;
                head2_d = DIR_LEFT;
            end

            S_PLACE2: state_d = S_GAME_WAIT;

            S_GAME_WAIT: begin
                // tick beats a simultaneous start; start is not honoured here
                if (tick) begin
                    state_d        = S_RD1;
                    head1_d        = new_heading(head1_q, dir1);
                    head2_d        = new_heading(head2_q, dir2);
                    {n1y_d, n1x_d} = next_pos(x1, y1, head1_d);
                    {n2y_d, n2x_d} = next_pos(x2, y2, head2_d);
                end
            end

            S_RD1: state_d = S_RD2;

            S_RD2: begin
                tile1_d = map_rdata;
                state_d = S_CHK;
            end

            S_CHK: begin
                // Heads landing on the same tile kill both players. Crossing
                // heads need no special case: each target already holds the
                // other player's head tile.
                same_tile = (n1x_q == n2x_q) && (n1y_q == n2y_q);
                hit1      = (tile1_q != TILE_EMPTY) || same_tile;
                hit2      = (map_rdata != TILE_EMPTY) || same_tile;
                if (hit1 && hit2) begin
                    state_d = S_END;
                    mode_d  = MODE_GAME_OVER;
                end else if (hit1) begin
                    state_d = S_END;
                    mode_d  = MODE_PLAYER2_WIN;
                end else if (hit2) begin
                    state_d = S_END;
                    mode_d  = MODE_PLAYER1_WIN;
                end else begin
                    state_d = S_WR1;
                    x1_d    = n1x_q;
                    y1_d    = n1y_q;
                end
            end

            S_WR1: begin
                state_d = S_WR2;
                x2_d    = n2x_q;
                y2_d    = n2y_q;
            end

            S_WR2: state_d = S_GAME_WAIT;

            default: state_d = S_IDLE_START;
        endcase

        // Outputs decoded from the state being entered, then registered
        case (state_d)
            S_IDLE_START: begin
                busy_d = 1'b0;
                mode_d = MODE_START;
            end
            S_CLEAR: begin
                mode_d      = MODE_START;
                map_we_d    = 1'b1;
                map_addr_d  = {cy_d, cx_d};
                map_wdata_d = is_frame(cx_d, cy_d) ? TILE_FRAME : TILE_EMPTY;
            end
            S_PLACE1: begin
                mode_d      = MODE_START;
                map_we_d    = 1'b1;
                map_addr_d  = {y1_d[5:0], x1_d[5:0]};
                map_wdata_d = TILE_PLAYER1;
            end
            S_PLACE2: begin
                mode_d      = MODE_START;
                map_we_d    = 1'b1;
                map_addr_d  = {y2_d[5:0], x2_d[5:0]};
                map_wdata_d = TILE_PLAYER2;
            end
            S_GAME_WAIT: begin
                busy_d = 1'b0;
                mode_d = MODE_GAME;
            end
            S_RD1: begin
                mode_d     = MODE_GAME;
                map_addr_d = {n1y_d[5:0], n1x_d[5:0]};
            end
            S_RD2, S_CHK: begin
                mode_d     = MODE_GAME;
                map_addr_d = {n2y_d[5:0], n2x_d[5:0]};
            end
            S_WR1: begin
                mode_d      = MODE_GAME;
                map_we_d    = 1'b1;
                map_addr_d  = {n1y_d[5:0], n1x_d[5:0]};
                map_wdata_d = TILE_PLAYER1;
            end
            S_WR2: begin
                mode_d      = MODE_GAME;
                map_we_d    = 1'b1;
                map_addr_d  = {n2y_d[5:0], n2x_d[5:0]};
                map_wdata_d = TILE_PLAYER2;
            end
            S_END: busy_d = 1'b0;   // mode keeps the outcome chosen in CHK
            default: busy_d = 1'b0;
        endcase
    end

    // State, datapath and output registers
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its pre-edge value regardless of statement order.
        if (rst) begin
            state_q   <= S_IDLE_START;
            cx_q      <= 6'd0;
            cy_q      <= 6'd0;
            head1_q   <= DIR_RIGHT;
            head2_q   <= DIR_LEFT;
            n1x_q     <= 8'd0;
            n1y_q     <= 8'd0;
            n2x_q     <= 8'd0;
            n2y_q     <= 8'd0;
            tile1_q   <= TILE_EMPTY;
            x1        <= SX1;
            y1        <= SY1;
            x2        <= SX2;
            y2        <= SY2;
            mode      <= MODE_START;
            map_addr  <= 12'd0;
            map_we    <= 1'b0;
            map_wdata <= TILE_EMPTY;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cx_q      <= cx_d;
            cy_q      <= cy_d;
            head1_q   <= head1_d;
            head2_q   <= head2_d;
            n1x_q     <= n1x_d;
            n1y_q     <= n1y_d;
            n2x_q     <= n2x_d;
            n2y_q     <= n2y_d;
            tile1_q   <= tile1_d;
            x1        <= x1_d;
            y1        <= y1_d;
            x2        <= x2_d;
            y2        <= y2_d;
            mode      <= mode_d;
            map_addr  <= map_addr_d;
            map_we    <= map_we_d;
            map_wdata <= map_wdata_d;
            busy      <= busy_d;
        end
    end

endmodule
